fetch_queue: RTL
================

# fetch_queue

Parameterised successor to the single-instruction fetch unit. It issues instruction requests to the instruction cache and buffers returned words with their PCs in a DEPTH-entry prefetch queue. The queue is presented to decode over a valid/ready handshake, and a redirect port flushes the queue and restarts fetch at a new PC. The block sits between the instruction cache and the decode unit.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / address width
- START_ADDR, 0, first fetch PC after reset
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- PC_STEP, 1, sequential PC increment (1 = word-addressed, 4 = byte-addressed)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- inst_req  out  1  request to cache; held high until inst_valid
- inst_addr  out  ADDR_WIDTH  request address; stable while inst_req high
- inst_valid  in  1  single-cycle pulse; inst_data valid for the one outstanding request
- inst_data  in  DATA_WIDTH  returned instruction
- dec_valid  out  1  queue head valid
- dec_inst  out  DATA_WIDTH  head instruction
- dec_pc  out  ADDR_WIDTH  head PC
- dec_ready  in  1  decode accepts head
- redirect  in  1  flush and restart fetch (branch/jump)
- redirect_pc  in  ADDR_WIDTH  restart PC
- queue_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc, state, circular queue (head/tail pointers, count), each entry = {pc, inst}.
- At most one cache request outstanding.
- push = accepted inst_valid. pop = dec_valid && dec_ready. count_next = count + push − pop. Pushing into a full queue is impossible by construction.
- FSM:
  - IDLE: inst_req=0. If !redirect and count_next<DEPTH: go to WAIT, set inst_req<=1 and inst_addr<=fetch_pc.
  - WAIT: on inst_valid without redirect:
    - Push {fetch_pc, inst_data}; fetch_pc += PC_STEP.
    - If count_next<DEPTH, stay in WAIT with inst_addr<=new fetch_pc (back-to-back). Otherwise go to IDLE with inst_req<=0.
  - DROP: inst_req=0; waiting on a response to discard. On inst_valid, go to IDLE with data dropped.
- Redirect (priority over push/pop/issue), in any state:
  - count/head/tail cleared; fetch_pc<=redirect_pc.
  - From IDLE: go to IDLE.
  - From WAIT with inst_valid in the same cycle: data dropped, go to IDLE.
  - From WAIT without inst_valid: go to DROP, inst_req<=0.
  - From DROP: stay in DROP unless inst_valid arrives in the same cycle, then go to IDLE.
- A dec handshake completing in a redirect cycle counts as consumed by decode.
- inst_valid in IDLE is ignored.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- dec_valid = (count≠0). dec_inst/dec_pc come from the head entry, registered and stable while dec_valid && !dec_ready.
- queue_count = count.

## Timing
- Reset values: inst_req 0, inst_addr START_ADDR, dec_valid 0, dec_inst 0, dec_pc 0, queue_count 0; fetch_pc START_ADDR; state IDLE; pointers 0.
- Reset mid-operation is abandoned immediately: queue emptied, outstanding request forgotten. The cache shares rst_n.
- The first cycle with rst_n high is spent in IDLE; inst_req rises on the next edge (cycle 1).
- inst_valid at cycle k: entry visible on dec_valid/dec_inst/dec_pc at k+1. The next inst_req/inst_addr (back-to-back case) is also updated at k+1.
- Sustained throughput is one instruction per cycle when the cache returns with zero extra wait cycles and dec_ready=1.
- pop at cycle k: next head visible at k+1; freed slot usable for issue decision at k.
- redirect at cycle r (not DROP): queue empty (dec_valid 0) at r+1; inst_req with inst_addr=redirect_pc at r+2.
- redirect at cycle r while awaiting a response: request at redirect_pc follows 2 cycles after the discarded inst_valid.

## Test plan
- Reset, then cache answers every request one cycle later with data 0xA0+addr, dec_ready=1 -> dec_pc 0,1,2,3… with dec_inst 0xA0,0xA1,…, no lost or duplicated entries.
- DEPTH=4, dec_ready=0 -> exactly 4 requests (addr 0–3), queue_count=4, inst_req stays 0. Raise dec_ready -> entries pop in order, request for addr 4 issues.
- In WAIT for addr 2, redirect=1 with redirect_pc=0x100, cache returns 0xDEAD two cycles later -> 0xDEAD never appears at decode, queue_count 0, next inst_addr=0x100.
- redirect to 0x40 in the same cycle as inst_valid (data 0xBEEF) -> 0xBEEF dropped, next request addr 0x40, first dec_pc=0x40.
- START_ADDR=0xFFFFFFFF, PC_STEP=1 -> request addrs 0xFFFFFFFF then 0x00000000, with matching dec_pc values.
- PC_STEP=4; plus rst_n pulsed low for one cycle mid-stream -> addrs 0,4,8. After the reset pulse, dec_valid 0, queue_count 0, and fetch restarts at START_ADDR.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetching fetch unit: issues one cache request at a time and
// buffers returned words with their PCs for decode; redirect flushes.
module fetch_queue #(
   parameter int                      DATA_WIDTH = 32,
   parameter int                      ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   START_ADDR = '0,
   parameter int                      DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0]   PC_STEP    = ADDR_WIDTH'(1),
   localparam int                     PW         = $clog2(DEPTH),
   localparam int                     CW         = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  inst_req,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  inst_valid,
   input  logic [DATA_WIDTH-1:0] inst_data,
   output logic                  dec_valid,
   output logic [DATA_WIDTH-1:0] dec_inst,
   output logic [ADDR_WIDTH-1:0] dec_pc,
   input  logic                  dec_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [CW-1:0]         queue_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_inst_addr;
   logic                  r_inst_req;
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;
   logic [ADDR_WIDTH-1:0] r_pc_q   [DEPTH];
   logic [DATA_WIDTH-1:0] r_inst_q [DEPTH];

   logic                  w_push;
   logic                  w_pop;
   logic [CW-1:0]         w_count_next;
   logic                  w_room;
   logic [ADDR_WIDTH-1:0] w_pc_inc;

   assign w_pop        = (r_count != '0) && dec_ready;
   assign w_push       = (r_state == S_WAIT) && inst_valid && !redirect;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   assign w_room       = w_count_next < CW'(DEPTH);
   assign w_pc_inc     = r_fetch_pc + PC_STEP;

   // Fetch FSM: request issue, back-to-back refetch and stale-response drop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= START_ADDR;
         r_inst_addr <= START_ADDR;
         r_inst_req  <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc <= redirect_pc;
         r_inst_req <= 1'b0;
         unique case (r_state)
            S_WAIT:  r_state <= inst_valid ? S_IDLE : S_DROP;
            S_DROP:  r_state <= inst_valid ? S_IDLE : S_DROP;
            default: r_state <= S_IDLE;
         endcase
      end else begin
         unique case (r_state)
            S_WAIT: begin
               if (inst_valid) begin
                  r_fetch_pc <= w_pc_inc;
                  if (w_room) begin
                     r_inst_addr <= w_pc_inc;
                  end else begin
                     r_state    <= S_IDLE;
                     r_inst_req <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (inst_valid) r_state <= S_IDLE;
            end
            default: begin
               if (w_room) begin
                  r_state     <= S_WAIT;
                  r_inst_req  <= 1'b1;
                  r_inst_addr <= r_fetch_pc;
               end
            end
         endcase
      end
   end

   // Circular prefetch queue; redirect empties it regardless of push/pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_q[i]   <= '0;
            r_inst_q[i] <= '0;
         end
      end else if (redirect) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_pc_q[r_tail]   <= r_fetch_pc;
            r_inst_q[r_tail] <= inst_data;
            r_tail           <= r_tail + PW'(1);
         end
         if (w_pop) r_head <= r_head + PW'(1);
         r_count <= w_count_next;
      end
   end

   assign inst_req    = r_inst_req;
   assign inst_addr   = r_inst_addr;
   assign dec_valid   = (r_count != '0);
   assign dec_inst    = r_inst_q[r_head];
   assign dec_pc      = r_pc_q[r_head];
   assign queue_count = r_count;

endmodule
